// File: rtl/pic_buf_loader.sv
// Fill controller for the 4-row x 16-byte picture buffer: loads four rows, then shifts in one row
// per consumer request. Define PIC_LOADER_ZEROPAD_EN to append up to three zero rows at the bottom.
module pic_buf_loader #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned ROW_STRIDE = 4,
   parameter int unsigned IMG_ROWS   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              next_row,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              pb_we,
   output logic              pb_shift,
   output logic [1:0]        pb_i,
   output logic [3:0]        pb_j,
   output logic [31:0]       pb_data,
   output logic              buf_ready,
   output logic [15:0]       row_idx,
   output logic              done
);

   typedef enum logic [2:0] {StIdle, StFill, StReady, StShift, StLoad, StDone} state_e;

   localparam logic [ADDR_W-1:0] Stride = ADDR_W'(ROW_STRIDE);

   state_e            state;
   logic [3:0]        cnt;       // {buffer row, word} of the read issued this cycle
   logic              issue;     // a read slot is active this cycle (also true for padded slots)
   logic              pad;       // current LOAD writes zeros instead of memory data
   logic [ADDR_W-1:0] row_base;  // address of word 0 of the most recently loaded image row
   logic              rows_left;
   logic              pad_ok;

   assign rows_left = (32'(row_idx) + 32'd4) < IMG_ROWS;
   assign pad_ok    = (32'(row_idx) + 32'd1) < IMG_ROWS;

   // Write data comes straight from the memory, which returns it the cycle after the read.
   assign pb_data = (pb_we && !pad) ? mem_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         cnt       <= 4'h0;
         issue     <= 1'b0;
         pad       <= 1'b0;
         row_base  <= '0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         pb_we     <= 1'b0;
         pb_shift  <= 1'b0;
         pb_i      <= 2'd0;
         pb_j      <= 4'd0;
         buf_ready <= 1'b0;
         row_idx   <= 16'd0;
         done      <= 1'b0;
      end else begin
         pb_shift <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state    <= StFill;
                  issue    <= 1'b1;
                  mem_rd   <= 1'b1;
                  mem_addr <= base_addr;
                  row_base <= base_addr;
                  cnt      <= 4'h0;
                  row_idx  <= 16'd0;
                  pad      <= 1'b0;
               end
            end
            StFill, StLoad: begin
               pb_we <= issue;
               pb_i  <= cnt[3:2];
               pb_j  <= {cnt[1:0], 2'b00};
               if (issue) begin
                  if (cnt == 4'hF) begin
                     issue  <= 1'b0;
                     mem_rd <= 1'b0;
                  end else begin
                     cnt <= cnt + 4'h1;
                     if (cnt[1:0] == 2'd3) begin
                        row_base <= row_base + Stride;
                        mem_addr <= row_base + Stride;
                     end else begin
                        mem_addr <= mem_addr + 1'b1;
                     end
                  end
               end else if (pb_we) begin
                  // Final write is on the bus this cycle.
                  state     <= StReady;
                  buf_ready <= 1'b1;
                  pb_we     <= 1'b0;
                  pad       <= 1'b0;
               end
            end
            StReady: begin
               if (next_row) begin
                  buf_ready <= 1'b0;
                  if (rows_left) begin
                     state    <= StShift;
                     pb_shift <= 1'b1;
`ifdef PIC_LOADER_ZEROPAD_EN
                  end else if (pad_ok) begin
                     state    <= StShift;
                     pb_shift <= 1'b1;
                     pad      <= 1'b1;
`endif
                  end else begin
                     state <= StDone;
                     done  <= 1'b1;
                  end
               end
            end
            StShift: begin
               state   <= StLoad;
               row_idx <= row_idx + 16'd1;
               issue   <= 1'b1;
               cnt     <= 4'hC;  // buffer row 3, word 0
               mem_rd  <= !pad;
               if (!pad) begin
                  row_base <= row_base + Stride;
                  mem_addr <= row_base + Stride;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   logic unused_pad_ok;
   assign unused_pad_ok = pad_ok;

endmodule

// File: tb/tb_pic_buf_loader.sv
// Directed self-checking bench for pic_buf_loader (ROW_STRIDE=8, IMG_ROWS=6, memory returns mem[a]=a).
module tb_pic_buf_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        next_row;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic        pb_we;
   logic        pb_shift;
   logic [1:0]  pb_i;
   logic [3:0]  pb_j;
   logic [31:0] pb_data;
   logic        buf_ready;
   logic [15:0] row_idx;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pic_buf_loader #(
      .ADDR_W    (16),
      .ROW_STRIDE(8),
      .IMG_ROWS  (6)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .next_row (next_row),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .pb_we    (pb_we),
      .pb_shift (pb_shift),
      .pb_i     (pb_i),
      .pb_j     (pb_j),
      .pb_data  (pb_data),
      .buf_ready(buf_ready),
      .row_idx  (row_idx),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (mem_rd) mem_rdata <= {16'h0, mem_addr};
   end

   function automatic logic [15:0] fill_addr(input logic [15:0] base, input int idx);
      return base + 16'((idx >> 2) * 8) + 16'(idx & 3);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; next_row = 1'b0; base_addr = 16'h0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({mem_rd, mem_addr, pb_we, pb_shift, pb_i, pb_j, pb_data, buf_ready, row_idx, done} !== 75'd0)
      begin
         errors++;
         $display("FAIL reset_outputs: rd=%b addr=%h we=%b sh=%b i=%0d j=%0d data=%h rdy=%b row=%0d done=%b, want all 0",
                  mem_rd, mem_addr, pb_we, pb_shift, pb_i, pb_j, pb_data, buf_ready, row_idx, done);
      end
   endtask

   // Fill from base 0x100; a second start with another base arrives mid-fill and must be ignored.
   task automatic test_fill();
      logic [15:0] ea;
      base_addr = 16'h0100; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         checks++;
         if (mem_rd !== (k <= 16)) begin
            errors++; $display("FAIL fill_rd c%0d: got %b want %b", k, mem_rd, (k <= 16));
         end
         if (k <= 16) begin
            ea = fill_addr(16'h0100, k - 1);
            checks++;
            if (mem_addr !== ea) begin
               errors++; $display("FAIL fill_addr c%0d: got %h want %h", k, mem_addr, ea);
            end
         end
         checks++;
         if (pb_we !== (k >= 2) || pb_shift !== 1'b0 || buf_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ctl c%0d: we=%b sh=%b rdy=%b want we=%b sh=0 rdy=0",
                               k, pb_we, pb_shift, buf_ready, (k >= 2));
         end
         if (k >= 2) begin
            ea = fill_addr(16'h0100, k - 2);
            checks++;
            if (pb_i !== 2'((k - 2) >> 2) || pb_j !== 4'(((k - 2) & 3) * 4) || pb_data !== {16'h0, ea})
            begin
               errors++; $display("FAIL fill_write c%0d: i=%0d j=%0d data=%h want i=%0d j=%0d data=%h",
                                  k, pb_i, pb_j, pb_data, (k - 2) >> 2, ((k - 2) & 3) * 4, ea);
            end
         end
         if (k == 5) begin start = 1'b1; base_addr = 16'h0200; end
         else start = 1'b0;
         tick();
      end
      checks++;
      if (buf_ready !== 1'b1 || pb_we !== 1'b0 || row_idx !== 16'd0) begin
         errors++; $display("FAIL fill_ready c18: rdy=%b we=%b row=%0d want rdy=1 we=0 row=0",
                            buf_ready, pb_we, row_idx);
      end
   endtask

   // One window advance; optionally a stray next_row during LOAD, or a padded (zero) row.
   task automatic test_advance(input logic [15:0] ra, input logic [15:0] exp_row, input bit inject,
                               input bit padded);
      next_row = 1'b1;
      tick();
      next_row = 1'b0;
      checks++;
      if (pb_shift !== 1'b1 || buf_ready !== 1'b0 || pb_we !== 1'b0 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL adv_shift row%0d: sh=%b rdy=%b we=%b rd=%b want sh=1 rdy=0 we=0 rd=0",
                            exp_row, pb_shift, buf_ready, pb_we, mem_rd);
      end
      tick();
      for (int j = 2; j <= 6; j++) begin
         checks++;
         if (mem_rd !== (!padded && j <= 5) || pb_we !== (j >= 3) || pb_shift !== 1'b0) begin
            errors++; $display("FAIL adv_ctl row%0d N+%0d: rd=%b we=%b sh=%b want rd=%b we=%b sh=0",
                               exp_row, j, mem_rd, pb_we, pb_shift, (!padded && j <= 5), (j >= 3));
         end
         if (!padded && j <= 5) begin
            checks++;
            if (mem_addr !== ra + 16'(j - 2)) begin
               errors++; $display("FAIL adv_addr row%0d N+%0d: got %h want %h",
                                  exp_row, j, mem_addr, ra + 16'(j - 2));
            end
         end
         if (j >= 3) begin
            checks++;
            if (pb_i !== 2'd3 || pb_j !== 4'((j - 3) * 4) ||
                pb_data !== (padded ? 32'h0 : {16'h0, ra + 16'(j - 3)})) begin
               errors++; $display("FAIL adv_write row%0d N+%0d: i=%0d j=%0d data=%h", exp_row, j,
                                  pb_i, pb_j, pb_data);
            end
         end
         next_row = (inject && j == 3);
         tick();
      end
      next_row = 1'b0;
      checks++;
      if (buf_ready !== 1'b1 || row_idx !== exp_row || pb_we !== 1'b0) begin
         errors++; $display("FAIL adv_ready: rdy=%b row=%0d we=%b want rdy=1 row=%0d we=0",
                            buf_ready, row_idx, pb_we, exp_row);
      end
   endtask

   task automatic test_done();
      next_row = 1'b1;
      tick();
      next_row = 1'b0;
      checks++;
      if (done !== 1'b1 || mem_rd !== 1'b0 || pb_shift !== 1'b0 || buf_ready !== 1'b0) begin
         errors++; $display("FAIL done_pulse: done=%b rd=%b sh=%b rdy=%b want 1 0 0 0",
                            done, mem_rd, pb_shift, buf_ready);
      end
      next_row = 1'b1;  // ignored once back in IDLE
      tick();
      checks++;
      if (done !== 1'b0 || buf_ready !== 1'b0 || mem_rd !== 1'b0) begin
         errors++; $display("FAIL done_idle: done=%b rdy=%b rd=%b want 0 0 0", done, buf_ready, mem_rd);
      end
      tick();
      next_row = 1'b0;
      checks++;
      if (pb_shift !== 1'b0 || mem_rd !== 1'b0 || pb_we !== 1'b0) begin
         errors++; $display("FAIL idle_next_row: sh=%b rd=%b we=%b want 0 0 0", pb_shift, mem_rd, pb_we);
      end
   endtask

   // Address wrap past 0xFFFF, then reset in fill cycle 9.
   task automatic test_wrap_reset();
      logic [15:0] exp_a [4];
      exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      base_addr = 16'hFFFE; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k <= 4) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== exp_a[k-1]) begin
               errors++; $display("FAIL wrap_addr c%0d: rd=%b addr=%h want rd=1 addr=%h",
                                  k, mem_rd, mem_addr, exp_a[k-1]);
            end
         end
         if (k == 9) rst = 1'b1;
         tick();
      end
      rst = 1'b0;
      checks++;
      if ({mem_rd, mem_addr, pb_we, pb_shift, pb_i, pb_j, pb_data, buf_ready, row_idx, done} !== 75'd0)
      begin
         errors++;
         $display("FAIL midfill_reset: rd=%b addr=%h we=%b i=%0d j=%0d data=%h rdy=%b want all 0",
                  mem_rd, mem_addr, pb_we, pb_i, pb_j, pb_data, buf_ready);
      end
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (pb_we !== 1'b0 || mem_rd !== 1'b0 || buf_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset c%0d: we=%b rd=%b rdy=%b want 0 0 0",
                               k, pb_we, mem_rd, buf_ready);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_advance(16'h0120, 16'd1, 1'b1, 1'b0);
      test_advance(16'h0128, 16'd2, 1'b0, 1'b0);
`ifdef PIC_LOADER_ZEROPAD_EN
      test_advance(16'h0000, 16'd3, 1'b0, 1'b1);
      test_advance(16'h0000, 16'd4, 1'b0, 1'b1);
      test_advance(16'h0000, 16'd5, 1'b0, 1'b1);
`endif
      test_done();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pic_buf_loader.md
# pic_buf_loader

Upstream fill controller for the 4-row × 16-byte convolution picture buffer. It reads 32-bit image words from a synchronous memory and drives the buffer's write and shift controls. The buffer is filled with the first four image rows, then advanced one row per consumer request until the image is exhausted. The downstream window consumer handshakes through `buf_ready`/`next_row`.

## Interface
- `ADDR_W`, 16: memory word-address width.
- `ROW_STRIDE`, 4: words per image row in memory. Must be ≥ 4; only words 0..3 of each row are loaded.
- `IMG_ROWS`, 16: image height in rows. Must be ≥ 4.

Ports:
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `base_addr` in ADDR_W: word address of image row 0, word 0; latched when `start` is accepted.
- `next_row` in 1: consumer request to advance the window; sampled only in READY.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory read address.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd`.
- `pb_we`, `pb_shift` out 1: buffer write enable and row shift.
- `pb_i` out 2: buffer row for the write.
- `pb_j` out 4: buffer byte column for the write; always 4×word index.
- `pb_data` out 32: write data; equals `mem_rdata` (or zero when padding).
- `buf_ready` out 1: the buffer holds a complete valid window.
- `row_idx` out 16: image row currently held in buffer row 0.
- `done` out 1: one-cycle end-of-frame pulse.

## Operation
- States:
  - **IDLE**
    - `start` → FILL.
  - **FILL**
    - 16 reads, row r = 0..3, word w = 0..3, w fastest.
    - Address = base + r·ROW_STRIDE + w.
  - **READY**
    - `next_row` with rows remaining → SHIFT.
    - `next_row` with no rows remaining → DONE.
  - **SHIFT**
    - `pb_shift` = 1 for one cycle → LOAD.
  - **LOAD**
    - 4 reads of image row `row_idx`+4 (after the increment), words 0..3.
    - Each write goes to `pb_i` = 3.
  - **DONE**
    - `done` = 1 for one cycle → IDLE.
- Writes trail their reads by exactly one cycle: registered `pb_i`/`pb_j` plus a valid bit. The state leaves FILL/LOAD only after the final write has issued.
- `pb_we` and `pb_shift` are never high in the same cycle.
- `row_idx` is cleared at `start` and increments at the SHIFT cycle.
- Rows remain while `row_idx`+4 < `IMG_ROWS`. Without padding, a frame yields `IMG_ROWS`−3 windows.
- Address arithmetic is modulo 2^ADDR_W; a wrap past the top of memory is legal.
- `start` outside IDLE and `next_row` outside READY are ignored.
- `next_row` held high advances once per READY entry.
- `rst` at any point:
  - state → IDLE next cycle;
  - in-flight read data is discarded;
  - all outputs go to 0.

## Timing
- Reset values: every output is 0 (`mem_addr`, `pb_i`, `pb_j`, `pb_data`, `row_idx` included).
- `start` sampled at edge E0:
  - `mem_rd` high cycles 1–16;
  - `pb_we` high cycles 2–17;
  - `buf_ready` high from cycle 18.
- `next_row` sampled at the edge ending cycle N:
  - `buf_ready` low from N+1;
  - `pb_shift` in N+1;
  - reads N+2..N+5;
  - writes N+3..N+6;
  - `buf_ready` high at N+7.
- Final `next_row` at cycle N: `done` = 1 in N+1, IDLE in N+2. A new `start` is accepted from N+2.

## Configuration
- `PIC_LOADER_ZEROPAD_EN`: bottom zero padding.
- Defined: when no image rows remain, `next_row` still performs SHIFT plus 4 writes to row 3.
  - `pb_data` = 0 and `mem_rd` stays 0; timing is identical to LOAD.
  - Up to 3 padded rows are inserted, giving `IMG_ROWS` windows per frame.
  - The next `next_row` → DONE.
- Undefined: padding logic is absent; the frame ends after `IMG_ROWS`−3 windows.

## Test plan
- Fill, with ROW_STRIDE=8, base=0x0100 and mem[a]=a:
  - `mem_addr` = 0x100–0x103, 0x108–0x10B, 0x110–0x113, 0x118–0x11B;
  - (`pb_i`,`pb_j`) = (0,0),(0,4),(0,8),(0,12),(1,0)…(3,12);
  - `pb_data` equals the address one cycle earlier;
  - `buf_ready` first high in cycle 18.
- Advance, after the fill above:
  - `next_row` at N → `pb_shift` in N+1;
  - reads 0x120–0x123; writes at `pb_i`=3, `pb_j` 0/4/8/12;
  - `buf_ready` at N+7; `row_idx`=1.
- Frame end, IMG_ROWS=6 without macro: two advances succeed; the third `next_row` → `done` for one cycle, then IDLE, no `mem_rd`.
- Robustness:
  - `start` during FILL and `next_row` during LOAD are ignored, with the address sequence unchanged;
  - `rst` at FILL cycle 9 → all outputs 0 next cycle and no further `pb_we`.
- Wrap: base=0xFFFE, ROW_STRIDE=4 → first addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- With `PIC_LOADER_ZEROPAD_EN`, IMG_ROWS=6:
  - advances 3–5 write `pb_data`=0 with `mem_rd`=0;
  - the sixth `next_row` → `done`.
